// File: rtl/mux_nto1_stream_pkg.sv
// Shared definitions for the N:1 stream multiplexer: mode encodings and the
// one-hot to binary index conversion used by the arbiter.
package mux_stream_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Upper bound on channel count and the matching index width.
    localparam int MAX_CH    = 16;
    localparam int MAX_IDX_W = 4;

    // Binary index of the set bit in a one-hot (or all-zero) vector.
    // An all-zero vector yields index 0.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_nto1_stream_arb.sv
// Combinational round-robin arbiter: grants the first requesting channel
// found when searching upward from ptr, wrapping at NUM_CH-1 back to 0.
module rr_arbiter_n
    import mux_stream_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]    req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [NUM_CH-1:0]    gnt,
    output logic [SEL_WIDTH-1:0] index
);

    logic                 found;
    int                   cand;
    logic [MAX_CH-1:0]    gnt_ext;
    logic [MAX_IDX_W-1:0] idx_full;
    logic                 unused_idx;

    // Rotating priority search starting at ptr; first requester wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            cand = (int'(ptr) + off) % NUM_CH;
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // Widen the grant to the package's fixed width and convert to an index.
    always_comb begin
        gnt_ext             = '0;
        gnt_ext[NUM_CH-1:0] = gnt;
        idx_full            = onehot_to_idx(gnt_ext);
        index               = idx_full[SEL_WIDTH-1:0];
        unused_idx          = ^idx_full;
    end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-channel stream multiplexer with a single registered output stage.
// Selection is either a fixed channel (sel) or round-robin over valid
// channels; the output register reloads whenever it is empty or drained.
module mux_nto1_stream
    import mux_stream_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_CH    = 4,
    parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_WIDTH-1:0]    sel,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]    out_ch,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic                 load_p0;
    logic                 sel_ok_p0;
    logic                 xfer_p0;
    logic [NUM_CH-1:0]    fix_gnt_p0;
    logic [NUM_CH-1:0]    rr_gnt_p0;
    logic [NUM_CH-1:0]    gnt_p0;
    logic [SEL_WIDTH-1:0] rr_idx_p0;
    logic [SEL_WIDTH-1:0] k_p0;
    logic [SEL_WIDTH-1:0] ptr_next_p0;
    logic [WIDTH-1:0]     beat_p0;

    logic [SEL_WIDTH-1:0] ptr;
    logic                 vld_p1;
    logic [WIDTH-1:0]     data_p1;
    logic [SEL_WIDTH-1:0] ch_p1;
    logic                 sel_err_p1;

    // ---- stage p0: arbitration and handshake ----

    rr_arbiter_n #(
        .NUM_CH    (NUM_CH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .gnt   (rr_gnt_p0),
        .index (rr_idx_p0)
    );

    // The register can accept a new beat when empty or when its beat leaves now.
    assign load_p0   = ~vld_p1 | out_ready;
    assign sel_ok_p0 = (int'(sel) < NUM_CH);

    // Fixed-mode grant: the selected channel only, and never an out-of-range one.
    always_comb begin
        fix_gnt_p0 = '0;
        if (sel_ok_p0) begin
            fix_gnt_p0[sel] = in_valid[sel];
        end
    end

    // Choose the grant source and granted index according to mode.
    always_comb begin
        if (mode == MODE_RR) begin
            gnt_p0 = rr_gnt_p0;
            k_p0   = rr_idx_p0;
        end else begin
            gnt_p0 = fix_gnt_p0;
            k_p0   = sel;
        end
    end

    // Ready only to the granted channel, and only when the register can load.
    always_comb begin
        in_ready = load_p0 ? gnt_p0 : '0;
        xfer_p0  = load_p0 & (|gnt_p0);
        beat_p0  = '0;
        if (|gnt_p0) begin
            beat_p0 = in_data[int'(k_p0)*WIDTH +: WIDTH];
        end
    end

    // Next pointer sits just past the channel that was served, wrapping to 0.
    always_comb begin
        if (rr_idx_p0 == SEL_WIDTH'(NUM_CH - 1)) begin
            ptr_next_p0 = '0;
        end else begin
            ptr_next_p0 = rr_idx_p0 + 1'b1;
        end
    end

    // ---- stage p1: output register, pointer and status ----

    // Output beat register: reload on load, hold data/channel when nothing granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
        end else if (load_p0) begin
            vld_p1 <= |gnt_p0;
            if (|gnt_p0) begin
                data_p1 <= beat_p0;
                ch_p1   <= k_p0;
            end
        end
    end

    // Round-robin pointer advances only on a round-robin transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer_p0 && (mode == MODE_RR)) begin
            ptr <= ptr_next_p0;
        end
    end

    // One-cycle-late, non-sticky flag for a fixed select pointing past NUM_CH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_p1 <= 1'b0;
        end else begin
            sel_err_p1 <= (mode == MODE_FIXED) && !sel_ok_p0 && (|in_valid);
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
    assign sel_err   = sel_err_p1;

endmodule
